// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit-stream path: FSM encodings and bit-order constant.
package serial_pkg;

  // One-hot state encoding, matching the downstream detector's FSM style.
  typedef enum logic [1:0] {
    IDLE  = 2'b01,
    SHIFT = 2'b10
  } state_t;

  // Value of MSB_FIRST that selects most-significant-bit-first emission.
  localparam bit MSB_ORDER = 1'b1;

endpackage

// File: rtl/word_bit_serializer_if.sv
// Parallel word handshake feeding the serializer (valid/ready, transfer = valid & ready).
interface word_bit_serializer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  // Word producer side.
  modport master (output s_data, output s_valid, input s_ready);
  // Serializer side.
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/word_bit_serializer_bit_tick_gen.sv
// Bit-rate divider: counts 0..CLK_DIV-1 while enabled, tick when the count is 0.
module bit_tick_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  // At least one bit wide so CLK_DIV=1 still has a (constant-zero) counter.
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] count_reg;

  // Divider counter; clr restarts a bit period so the next tick is immediate.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign tick = en && (count_reg == '0);
endmodule

// File: rtl/word_bit_serializer.sv
// Word-to-bit serializer with a one-word holding register for gap-free streaming.
module word_bit_serializer
  import serial_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  word_bit_serializer_if.slave  word,
  output logic                  bit_out,
  output logic                  bit_valid,
  output logic                  sof,
  output logic                  eof,
  output logic                  busy
);
  // Reject parameter sets the datapath cannot support.
  if (DATA_W < 2) begin : g_bad_data_w
    $error("word_bit_serializer: DATA_W must be >= 2");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("word_bit_serializer: CLK_DIV must be >= 1");
  end

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] hold_reg;
  logic              hold_full_reg;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              full_reg, full_next;   // shifter holds un-emitted bits
  logic              bit_out_reg, bit_out_next;
  logic              bit_valid_reg, bit_valid_next;
  logic              sof_reg, sof_next;
  logic              eof_reg, eof_next;
  logic              busy_reg, busy_next;
  logic              load, div_clr, tick, transfer;
  logic              cur_bit;
  logic [DATA_W-1:0] shifted;

  assign word.s_ready = !rst && !hold_full_reg;
  assign transfer     = word.s_valid && word.s_ready;

  assign cur_bit = (MSB_FIRST == MSB_ORDER) ? shift_reg[DATA_W-1] : shift_reg[0];
  assign shifted = (MSB_FIRST == MSB_ORDER) ? {shift_reg[DATA_W-2:0], 1'b0}
                                            : {1'b0, shift_reg[DATA_W-1:1]};

  bit_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (div_clr),
    .en   (state_reg == SHIFT),
    .tick (tick)
  );

  // Holding register: captured on transfer, freed when the shifter loads it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      if (transfer) hold_reg <= word.s_data;
      hold_full_reg <= transfer || (hold_full_reg && !load);
    end
  end

  // State, shifter and registered serial outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      cnt_reg       <= '0;
      full_reg      <= 1'b0;
      bit_out_reg   <= 1'b0;
      bit_valid_reg <= 1'b0;
      sof_reg       <= 1'b0;
      eof_reg       <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      cnt_reg       <= cnt_next;
      full_reg      <= full_next;
      bit_out_reg   <= bit_out_next;
      bit_valid_reg <= bit_valid_next;
      sof_reg       <= sof_next;
      eof_reg       <= eof_next;
      busy_reg      <= busy_next;
    end
  end

  // Next-state logic: load from hold in IDLE, emit one bit per tick in SHIFT.
  // A reload at the last bit leaves the divider running, so the next word's
  // first strobe lands one full bit period later with no gap.
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    cnt_next       = cnt_reg;
    full_next      = full_reg;
    bit_out_next   = bit_out_reg;
    bit_valid_next = 1'b0;
    sof_next       = 1'b0;
    eof_next       = 1'b0;
    load           = 1'b0;
    div_clr        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hold_full_reg) begin
          load       = 1'b1;
          div_clr    = 1'b1;
          shift_next = hold_reg;
          cnt_next   = '0;
          full_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (full_reg) begin
            bit_out_next   = cur_bit;
            bit_valid_next = 1'b1;
            sof_next       = (cnt_reg == '0);
            eof_next       = (cnt_reg == LAST_BIT);
            shift_next     = shifted;
            if (cnt_reg == LAST_BIT) begin
              cnt_next = '0;
              if (hold_full_reg) begin
                load       = 1'b1;
                shift_next = hold_reg;
              end else begin
                full_next = 1'b0;
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end else begin
            // Trailing bit period of the last word has elapsed.
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    busy_next = full_next || bit_valid_next;
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign sof       = sof_reg;
  assign eof       = eof_reg;
  assign busy      = busy_reg;
endmodule

// File: tb/tb_word_bit_serializer.sv
// Self-checking bench: three serializer configurations on one clock.
//   u0: CLK_DIV=1 MSB first, u1: CLK_DIV=3 MSB first, u2: CLK_DIV=1 LSB first.
module tb_word_bit_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic [7:0] sd  [3];
  logic       sv  [3];
  logic       sr  [3];
  logic       bo  [3];
  logic       bv  [3];
  logic       sf  [3];
  logic       ef  [3];
  logic       bz  [3];

  word_bit_serializer_if #(.DATA_W(8)) if0 ();
  word_bit_serializer_if #(.DATA_W(8)) if1 ();
  word_bit_serializer_if #(.DATA_W(8)) if2 ();

  assign if0.s_data = sd[0]; assign if0.s_valid = sv[0]; assign sr[0] = if0.s_ready;
  assign if1.s_data = sd[1]; assign if1.s_valid = sv[1]; assign sr[1] = if1.s_ready;
  assign if2.s_data = sd[2]; assign if2.s_valid = sv[2]; assign sr[2] = if2.s_ready;

  word_bit_serializer #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b1)) u0 (
    .clk(clk), .rst(rst[0]), .word(if0), .bit_out(bo[0]), .bit_valid(bv[0]),
    .sof(sf[0]), .eof(ef[0]), .busy(bz[0]));
  word_bit_serializer #(.DATA_W(8), .CLK_DIV(3), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .rst(rst[1]), .word(if1), .bit_out(bo[1]), .bit_valid(bv[1]),
    .sof(sf[1]), .eof(ef[1]), .busy(bz[1]));
  word_bit_serializer #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .rst(rst[2]), .word(if2), .bit_out(bo[2]), .bit_valid(bv[2]),
    .sof(sf[2]), .eof(ef[2]), .busy(bz[2]));

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endfunction

  // Expected serial order is written with the first emitted bit at [7].
  typedef struct {
    int         sel;
    logic [7:0] word;
    logic [7:0] exp_seq;
    int         gap;
  } vec_t;
  vec_t vecs [7];

  // Sends one word to instance sel (shifter idle) and checks every strobe.
  task automatic send_word(input int sel, input logic [7:0] w, input logic [7:0] exp,
                           input int gap, input string tag, output logic [7:0] got);
    int   k, n, first, prev, late;
    logic held;
    bit   acc;
    got = '0; n = 0; first = -1; prev = -1; held = 1'b0; acc = 1'b0; late = 0;
    sd[sel] = w; sv[sel] = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      if (sr[sel]) acc = 1'b1;
      @(negedge clk);
    end
    sv[sel] = 1'b0;
    check({tag, " accepted"}, 32'(acc), 1);
    k = 0;
    while (n < 8 && k < 120) begin
      if (bv[sel]) begin
        got = {got[6:0], bo[sel]};
        check($sformatf("%s bit%0d", tag, n), 32'(bo[sel]), 32'(exp[7-n]));
        check($sformatf("%s sof%0d", tag, n), 32'(sf[sel]), 32'(n == 0));
        check($sformatf("%s eof%0d", tag, n), 32'(ef[sel]), 32'(n == 7));
        check($sformatf("%s busy%0d", tag, n), 32'(bz[sel]), 1);
        if (n == 0) begin
          check({tag, " first latency"}, 32'(k), 2);
          first = k;
        end else begin
          check($sformatf("%s spacing%0d", tag, n), 32'(k - prev), 32'(gap));
        end
        held = bo[sel]; prev = k; n++;
      end else begin
        if (n > 0) check($sformatf("%s hold k%0d", tag, k), 32'(bo[sel]), 32'(held));
        check($sformatf("%s sof/eof idle k%0d", tag, k), {30'd0, sf[sel], ef[sel]}, 0);
      end
      if (n < 8) begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, " strobe count"}, 32'(n), 8);
    check({tag, " span"}, 32'(prev - first + 1), 32'(7 * gap + 1));
    @(negedge clk);
    check({tag, " busy after"}, 32'(bz[sel]), 0);
    for (int i = 0; i < gap + 3; i++) begin
      if (bv[sel]) late++;
      @(negedge clk);
    end
    check({tag, " no late strobe"}, 32'(late), 0);
  endtask

  logic [7:0]  got;
  logic [15:0] got16;
  int          n, prev, n_acc, extra, max_run, run;
  bit          will_acc, saw_low;

  initial begin
    vecs[0] = '{0, 8'hA5, 8'b1010_0101, 1};
    vecs[1] = '{0, 8'h3C, 8'b0011_1100, 1};
    vecs[2] = '{1, 8'h81, 8'b1000_0001, 3};
    vecs[3] = '{1, 8'h5A, 8'b0101_1010, 3};
    vecs[4] = '{2, 8'h01, 8'b1000_0000, 1};
    vecs[5] = '{2, 8'hB2, 8'b0100_1101, 1};
    vecs[6] = '{2, 8'hC4, 8'b0010_0011, 1};

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; sd[i] = '0; sv[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset outs u%0d", i), {27'd0, bo[i], bv[i], sf[i], ef[i], bz[i]}, 0);
      check($sformatf("reset s_ready u%0d", i), 32'(sr[i]), 0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check($sformatf("s_ready after rst u%0d", i), 32'(sr[i]), 1);
    @(negedge clk);

    // Table-driven single-word vectors.
    for (int i = 0; i < 7; i++) begin
      send_word(vecs[i].sel, vecs[i].word, vecs[i].exp_seq, vecs[i].gap,
                $sformatf("vec%0d", i), got);
    end

    // Back-to-back words FF then 00 must stream as 16 contiguous strobes.
    sd[0] = 8'hFF; sv[0] = 1'b1; n_acc = 0; n = 0; prev = 0; saw_low = 0;
    will_acc = 0; got16 = '0;
    for (int k = 0; k < 60 && n < 16; k++) begin
      if (will_acc) begin
        n_acc++;
        if (n_acc == 1) sd[0] = 8'h00;
        else sv[0] = 1'b0;
      end
      if (bv[0]) begin
        got16 = {got16[14:0], bo[0]};
        check($sformatf("b2b sof%0d", n), 32'(sf[0]), 32'(n == 0 || n == 8));
        check($sformatf("b2b eof%0d", n), 32'(ef[0]), 32'(n == 7 || n == 15));
        if (n > 0) check($sformatf("b2b contiguous%0d", n), 32'(k - prev), 1);
        prev = k; n++;
      end
      if (n_acc >= 1 && !sr[0]) saw_low = 1'b1;
      will_acc = sv[0] && sr[0];
      @(negedge clk);
    end
    check("b2b strobes", 32'(n), 16);
    check("b2b bits", 32'(got16), 32'h0000_FF00);
    check("b2b ready low while held", 32'(saw_low), 1);
    check("b2b transfers", 32'(n_acc), 2);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      if (bv[0]) extra++;
      @(negedge clk);
    end
    check("b2b no extra strobes", 32'(extra), 0);

    // Reset at the 4th strobe of F0 with 0F held: both words are dropped.
    sd[0] = 8'hF0; sv[0] = 1'b1; n_acc = 0; n = 0; will_acc = 0; got = '0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      if (will_acc) begin
        n_acc++;
        if (n_acc == 1) sd[0] = 8'h0F;
        else sv[0] = 1'b0;
      end
      if (bv[0]) begin
        got = {got[6:0], bo[0]};
        n++;
      end
      will_acc = sv[0] && sr[0];
      if (n < 4) @(negedge clk);
    end
    check("rst-mid strobes before rst", 32'(n), 4);
    check("rst-mid bits before rst", 32'(got[3:0]), 32'hF);
    check("rst-mid second word held", 32'(n_acc), 2);
    sv[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    check("rst-mid s_ready during rst", 32'(sr[0]), 0);
    @(negedge clk);
    rst[0] = 1'b0;
    check("rst-mid outs after rst", {29'd0, bv[0], bz[0], ef[0]}, 0);
    #1;
    check("rst-mid s_ready after rst", 32'(sr[0]), 1);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bv[0]) extra++;
    end
    check("rst-mid no later bits", 32'(extra), 0);

    // Idle with s_valid low, then E0 into a run-length detector model.
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      if (bv[0]) extra++;
      @(negedge clk);
    end
    check("idle no strobes", 32'(extra), 0);
    send_word(0, 8'hE0, 8'b1110_0000, 1, "det", got);
    max_run = 0; run = 0;
    for (int i = 7; i >= 0; i--) begin
      run = got[i] ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    check("det run of ones", 32'(max_run), 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
